// File: rtl/uart_pkg.sv
// Shared UART definitions: word type and default link timing used by the
// receiver, the transmitter and the receive FIFO.
package uart_pkg;

  typedef logic [7:0] uart_word_t;

  localparam int unsigned BAUD_RATE  = 115_200;
  localparam int unsigned CLOCK_RATE = 50_000_000;

endpackage : uart_pkg

// File: rtl/uart_edge_detect.sv
// Rising-edge detector for a level strobe. The registered copy resets to 1,
// so a level that is already high when reset releases gives no pulse.
// Reused for the transmitter start strobe.
module uart_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_d;
  logic level_q;

  // Next value of the delayed level and the one-cycle rise pulse
  always_comb begin
    level_d = level;
    rise    = level & ~level_q;
  end

  // Delayed copy of the level, held high through reset
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_d;
    end
  end

endmodule : uart_edge_detect

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver. Each rising edge of in_valid writes
// one word; the consumer reads through a first-word-fall-through valid/ready
// port. A word arriving while full with no pop is dropped and sets the sticky
// overflow flag. Defining UART_RX_FIFO_DROP_COUNT_EN adds a saturating
// 16-bit drop_count output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = $bits(uart_word_t),
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    overflow,
  input  logic                    clear_overflow
`ifdef UART_RX_FIFO_DROP_COUNT_EN
  ,
  output logic [15:0]             drop_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  full_w;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_d, wr_ptr_q;
  logic [PW-1:0]         rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]         count_d, count_q;
  logic                  overflow_d, overflow_q;

  uart_edge_detect u_in_edge (
    .clk   (clk),
    .rst   (rst),
    .level (in_valid),
    .rise  (push_req)
  );

  // Push/pop/drop decisions and next pointer, occupancy and overflow state
  always_comb begin
    full_w   = (count_q == CW'(DEPTH));
    pop      = (count_q != '0) & out_ready;
    push     = push_req & (~full_w | pop);
    drop     = push_req & full_w & ~pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Storage: written on accepted pushes only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Pointer, occupancy and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign full      = full_w;
  assign overflow  = overflow_q;

`ifdef UART_RX_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count_d, drop_count_q;

  // Saturating drop counter; a clear together with a drop restarts at one
  always_comb begin
    drop_count_d = drop_count_q;
    if (clear_overflow) begin
      drop_count_d = drop ? 16'd1 : '0;
    end else if (drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 1'b1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a constant vector table for the
// single-word case, hand-written multi-cycle corner sequences, and a random
// phase, all compared against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  count;
  logic        full;
  logic        overflow;
  logic        clear_overflow = 1'b0;
`ifdef UART_RX_FIFO_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents as a queue, previous in_valid level, flags
  uart_word_t mq[$];
  bit         m_prev  = 1'b1;
  bit         m_ovf   = 1'b0;
  int         m_drops = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules for one clock edge using the inputs present at that edge
  task automatic model_update();
    bit req, pop, drop;
    if (rst) begin
      mq.delete();
      m_prev  = 1'b1;
      m_ovf   = 1'b0;
      m_drops = 0;
      return;
    end
    req  = in_valid && !m_prev;
    pop  = (mq.size() != 0) && out_ready;
    drop = req && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (req && !drop) mq.push_back(in_data);
    if (drop) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    if (clear_overflow) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < 65535) m_drops++;
    m_prev = in_valid;
  endtask

  task automatic model_check();
    chk("m_count", count, mq.size());
    chk("m_out_valid", out_valid, mq.size() != 0);
    chk("m_full", full, mq.size() == DEPTH);
    chk("m_overflow", overflow, m_ovf);
    if (mq.size() != 0) chk("m_out_data", out_data, mq[0]);
`ifdef UART_RX_FIFO_DROP_COUNT_EN
    chk("m_drop_count", drop_count, m_drops);
`endif
  endtask

  // Drive inputs away from the edge, clock once, sample 1 time unit later
  task automatic step(input bit iv, input logic [7:0] d, input bit rdy,
                      input bit clr, input bit r);
    in_valid       = iv;
    in_data        = d;
    out_ready      = rdy;
    clear_overflow = clr;
    rst            = r;
    @(posedge clk);
    model_update();
    #1;
    model_check();
  endtask

  task automatic push_word(input logic [7:0] d, input bit rdy);
    step(1'b1, d, rdy, 1'b0, 1'b0);
    step(1'b0, d, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit         r;
    bit         iv;
    logic [7:0] d;
    bit         rdy;
    logic [4:0] ec;
    bit         ev;
    logic [7:0] ed;
    bit         ef;
    bit         eo;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // r, iv, d, rdy -> count, valid, data, full, overflow
    tbl[0]  = '{1, 0, 8'h00, 0, 5'd0, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 0, 8'h00, 0, 5'd0, 0, 8'h00, 0, 0};
    tbl[2]  = '{0, 1, 8'h41, 0, 5'd1, 1, 8'h41, 0, 0};
    tbl[3]  = '{0, 1, 8'h41, 0, 5'd1, 1, 8'h41, 0, 0};
    tbl[4]  = '{0, 1, 8'h41, 0, 5'd1, 1, 8'h41, 0, 0};
    tbl[5]  = '{0, 1, 8'h41, 0, 5'd1, 1, 8'h41, 0, 0};
    tbl[6]  = '{0, 1, 8'h41, 0, 5'd1, 1, 8'h41, 0, 0};
    tbl[7]  = '{0, 0, 8'h41, 1, 5'd0, 0, 8'h00, 0, 0};
    tbl[8]  = '{0, 0, 8'h00, 1, 5'd0, 0, 8'h00, 0, 0};
    tbl[9]  = '{0, 1, 8'h5A, 1, 5'd1, 1, 8'h5A, 0, 0};
    tbl[10] = '{0, 0, 8'h5A, 1, 5'd0, 0, 8'h00, 0, 0};

    // Single word, held level, empty-pop and no-bypass vectors
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].rdy, 1'b0, tbl[i].r);
      chk("tbl_count", count, tbl[i].ec);
      chk("tbl_valid", out_valid, tbl[i].ev);
      chk("tbl_full", full, tbl[i].ef);
      chk("tbl_overflow", overflow, tbl[i].eo);
      if (tbl[i].ev) chk("tbl_data", out_data, tbl[i].ed);
    end

    // Ordering and pointer wrap: 24 words, occupancy never above 15
    do_reset();
    for (int i = 0; i < 15; i++) push_word(8'(i), 1'b0);
    for (int i = 15; i < 24; i++) begin
      chk("wrap_order", out_data, 8'(i - 15));
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      step(1'b0, 8'(i), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 9; i < 24; i++) begin
      chk("wrap_drain", out_data, 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("wrap_empty", count, 5'd0);

    // Overflow: 17 words with no consumer, the last one is dropped
    do_reset();
    for (int i = 0; i < 17; i++) push_word(8'(8'h10 + i), 1'b0);
    chk("ovf_count", count, 5'd16);
    chk("ovf_full", full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", out_data, 8'(8'h10 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("ovf_empty", out_valid, 1'b0);
    chk("ovf_sticky", overflow, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("ovf_cleared", overflow, 1'b0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_word(8'(8'h30 + i), 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", count, 5'd16);
    chk("fullpp_ovf", overflow, 1'b0);
    step(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_drain", out_data, (i < 15) ? 8'(8'h31 + i) : 8'hAA);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // Reset during operation with in_valid held high
    for (int i = 0; i < 4; i++) push_word(8'(8'h60 + i), 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("rst_pre_count", count, 5'd5);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("rst_count", count, 5'd0);
    chk("rst_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    chk("rst_held_nopush", count, 5'd0);
    step(1'b0, 8'h88, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    chk("rst_repush_count", count, 5'd1);
    chk("rst_repush_data", out_data, 8'h88);

`ifdef UART_RX_FIFO_DROP_COUNT_EN
    // Drop counter: three drops, then a drop together with a clear
    do_reset();
    for (int i = 0; i < 16; i++) push_word(8'(i), 1'b0);
    for (int i = 0; i < 3; i++) push_word(8'hEE, 1'b0);
    chk("drop_count_3", drop_count, 16'd3);
    step(1'b1, 8'hEF, 1'b0, 1'b1, 1'b0);
    chk("drop_count_clr", drop_count, 16'd1);
    chk("drop_ovf_set", overflow, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 40) == 0), ($urandom_range(0, 400) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_fifo
